decomp_seq_feeder: RTL and testbench

- Upstream pacing stage for the sequential decomposer, which takes one coefficient and emits L levels, one per cycle.
- The decomposer flags an error if a new coefficient arrives less than L cycles after the previous one.
- This block accepts coefficients on a valid/ready stream and buffers them in a small FIFO.
- It issues them as single-cycle avail pulses spaced at least L cycles apart, so the decomposer never overruns.

---
 rtl/decomp_seq_feeder.sv | 129 ++++++++++++
 tb/tb_decomp_seq_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decomp_seq_feeder.sv
// Purpose : paces coefficients into the sequential decomposer so issues are at least L cycles apart.
// Latency : accept at edge k into an idle, empty block gives dcp_avail in the cycle after edge k+1.
// Backpressure: in_rdy = !full, taken from registered occupancy only (a pop never re-opens it in-cycle).
// Ports:
//   clk, a_rst_n                 clock, asynchronous active-low reset
//   in_data/in_side/in_vld/in_rdy upstream valid/ready stream
//   dcp_data/dcp_side/dcp_avail   registered coefficient + one-cycle issue pulse to the decomposer
//   fill_cnt, busy               FIFO occupancy; activity flag (entries buffered or spacing pending)
module decomp_seq_feeder #(
  parameter int OP_W   = 64,
  parameter int L      = 3,
  parameter int SIDE_W = 1,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       a_rst_n,
  input  logic [OP_W-1:0]            in_data,
  input  logic [SIDE_W-1:0]          in_side,
  input  logic                       in_vld,
  output logic                       in_rdy,
  output logic [OP_W-1:0]            dcp_data,
  output logic [SIDE_W-1:0]          dcp_side,
  output logic                       dcp_avail,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GAP_W = (L > 1) ? $clog2(L) : 1;
  localparam int ENT_W = OP_W + SIDE_W;

  typedef enum logic {
    ST_IDLE,
    ST_SPACE
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   fill_q, fill_d;
  logic               avail_q;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [OP_W-1:0]    dcp_data_q;
  logic [SIDE_W-1:0]  dcp_side_q;
  logic               push;
  logic               pop;

  // Ready depends only on the registered count, so a pop while full
  // cannot combinationally re-open the input in the same cycle.
  assign in_rdy = (fill_q != CNT_W'(DEPTH));
  assign push   = in_vld & in_rdy;
  // Issue only while no spacing is pending; the head is consumed on issue.
  assign pop    = (state_q == ST_IDLE) & (fill_q != '0);

  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Spacing FSM: after an issue, hold off L-1 further cycles so the next
  // issue lands exactly L cycles later. With L=1 it never leaves IDLE.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (pop && (L > 1)) begin
          gap_d   = GAP_W'(L - 1);
          state_d = ST_SPACE;
        end
      end
      ST_SPACE: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      avail_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      fill_q   <= fill_d;
      avail_q  <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Datapath storage carries no reset; contents are only meaningful
  // once qualified by occupancy or by an issue pulse.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_data, in_side};
    end
    if (pop) begin
      {dcp_data_q, dcp_side_q} <= mem_q[rd_ptr_q];
    end
  end

  assign dcp_data  = dcp_data_q;
  assign dcp_side  = dcp_side_q;
  assign dcp_avail = avail_q;
  assign fill_cnt  = fill_q;
  assign busy      = (fill_q != '0) | (gap_q != '0);

endmodule

// File: tb/tb_decomp_seq_feeder.sv
// Purpose : self-checking bench for decomp_seq_feeder, one instance with L=3 and one with L=1.
// Latency : a reference model predicts every output after each clock edge.
// Backpressure: the model applies in_rdy = occupancy below DEPTH.
module tb_decomp_seq_feeder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        a_rst_n;

  logic [63:0] data3, dd3, data1, dd1;
  logic        side3, ds3, side1, ds1;
  logic        vld3, rdy3, av3, busy3;
  logic        vld1, rdy1, av1, busy1;
  logic [2:0]  fc3, fc1;

  decomp_seq_feeder #(.OP_W(64), .L(3), .SIDE_W(1), .DEPTH(DEPTH)) u3 (
    .clk(clk), .a_rst_n(a_rst_n),
    .in_data(data3), .in_side(side3), .in_vld(vld3), .in_rdy(rdy3),
    .dcp_data(dd3), .dcp_side(ds3), .dcp_avail(av3),
    .fill_cnt(fc3), .busy(busy3)
  );

  decomp_seq_feeder #(.OP_W(64), .L(1), .SIDE_W(1), .DEPTH(DEPTH)) u1 (
    .clk(clk), .a_rst_n(a_rst_n),
    .in_data(data1), .in_side(side1), .in_vld(vld1), .in_rdy(rdy1),
    .dcp_data(dd1), .dcp_side(ds1), .dcp_avail(av1),
    .fill_cnt(fc1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: a queue of accepted entries per instance, plus the
  // edge number of the last issue. An issue happens at an edge when the
  // queue was non-empty before it and at least L edges have elapsed since
  // the previous issue.
  int          ml   [2] = '{3, 1};
  logic [64:0] mq0[$];
  logic [64:0] mq1[$];
  int          last [2];
  bit          ever [2];
  bit          expav[2];
  logic [64:0] expd [2];
  bit          took [2];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic pre(input int i, input logic vld, output bit pu, output bit po);
    int sz;
    sz = qsize(i);
    pu = vld && (sz < DEPTH);
    po = (sz != 0) && (!ever[i] || (cyc + 1 - last[i]) >= ml[i]);
  endtask

  task automatic check_outputs();
    int sz;
    bit gap_busy;
    sz = qsize(0);
    gap_busy = ever[0] && ((cyc - last[0]) < (ml[0] - 1));
    chk("avail_L3", {64'd0, av3}, {64'd0, expav[0]});
    if (ever[0]) chk("data_L3", {dd3, ds3}, expd[0]);
    chk("rdy_L3", {64'd0, rdy3}, {64'd0, (sz != DEPTH)});
    chk("fill_L3", {62'd0, fc3}, 65'(sz));
    chk("busy_L3", {64'd0, busy3}, {64'd0, (sz != 0) || gap_busy});
    sz = qsize(1);
    gap_busy = ever[1] && ((cyc - last[1]) < (ml[1] - 1));
    chk("avail_L1", {64'd0, av1}, {64'd0, expav[1]});
    if (ever[1]) chk("data_L1", {dd1, ds1}, expd[1]);
    chk("rdy_L1", {64'd0, rdy1}, {64'd0, (sz != DEPTH)});
    chk("fill_L1", {62'd0, fc1}, 65'(sz));
    chk("busy_L1", {64'd0, busy1}, {64'd0, (sz != 0) || gap_busy});
  endtask

  task automatic tick();
    bit pu0, po0, pu1, po1;
    pre(0, vld3, pu0, po0);
    pre(1, vld1, pu1, po1);
    @(posedge clk);
    cyc++;
    if (po0) begin expd[0] = mq0.pop_front(); last[0] = cyc; ever[0] = 1'b1; end
    if (po1) begin expd[1] = mq1.pop_front(); last[1] = cyc; ever[1] = 1'b1; end
    expav[0] = po0;
    expav[1] = po1;
    if (pu0) mq0.push_back({data3, side3});
    if (pu1) mq1.push_back({data1, side1});
    took[0] = pu0;
    took[1] = pu1;
    #1;
    check_outputs();
  endtask

  // Reset is asserted away from the clock edge; outputs must clear at once.
  task automatic apply_reset();
    a_rst_n = 1'b0;
    vld3 = 1'b0;
    vld1 = 1'b0;
    #1;
    mq0.delete();
    mq1.delete();
    for (int i = 0; i < 2; i++) begin
      ever[i] = 1'b0; expav[i] = 1'b0; last[i] = 0; took[i] = 1'b0;
    end
    check_outputs();
    repeat (2) @(posedge clk);
    cyc += 2;
    #2;
    a_rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int n;
    int guard;
    bit saw_full;
    a_rst_n = 1'b0;
    vld3 = 1'b0; data3 = '0; side3 = 1'b0;
    vld1 = 1'b0; data1 = '0; side1 = 1'b0;

    apply_reset();
    repeat (3) tick();

    // Single push into an idle block: pulse exactly two edges after accept.
    vld3 = 1'b1; data3 = 64'h0123_4567_89AB_CDEF; side3 = 1'b1;
    tick();
    vld3 = 1'b0;
    chk("lat_first_no_early", {64'd0, av3}, 65'd0);
    tick();
    chk("lat_first_pulse", {64'd0, av3}, 65'd1);
    chk("lat_first_data", {dd3, ds3}, {64'h0123_4567_89AB_CDEF, 1'b1});
    repeat (8) tick();

    // Burst of four back-to-back pushes.
    for (int i = 0; i < 4; i++) begin
      vld3 = 1'b1; data3 = rnd64(); side3 = 1'($urandom);
      tick();
    end
    vld3 = 1'b0;
    repeat (14) tick();

    // Continuous valid for eight values: the FIFO must fill and stall.
    n = 0; guard = 0; saw_full = 1'b0;
    vld3 = 1'b1; data3 = rnd64(); side3 = 1'($urandom);
    while (n < 8 && guard < 100) begin
      tick();
      guard++;
      if (!rdy3) saw_full = 1'b1;
      if (took[0]) begin
        n++;
        data3 = rnd64(); side3 = 1'($urandom);
      end
    end
    vld3 = 1'b0;
    chk("cont_all_accepted", 65'(n), 65'd8);
    chk("cont_saw_full", {64'd0, saw_full}, 65'd1);
    repeat (30) tick();

    // L=1: one issue per cycle.
    for (int i = 0; i < 6; i++) begin
      vld1 = 1'b1; data1 = rnd64(); side1 = 1'($urandom);
      tick();
    end
    vld1 = 1'b0;
    repeat (5) tick();

    // Reset mid-operation with entries buffered and spacing pending.
    for (int i = 0; i < 4; i++) begin
      vld3 = 1'b1; data3 = rnd64(); side3 = 1'($urandom);
      vld1 = 1'b1; data1 = rnd64(); side1 = 1'($urandom);
      tick();
    end
    vld3 = 1'b0; vld1 = 1'b0;
    tick();
    apply_reset();
    tick();
    vld3 = 1'b1; data3 = 64'hFEDC_BA98_7654_3210; side3 = 1'b0;
    tick();
    vld3 = 1'b0;
    tick();
    chk("post_rst_pulse", {64'd0, av3}, 65'd1);
    chk("post_rst_data", {dd3, ds3}, {64'hFEDC_BA98_7654_3210, 1'b0});
    repeat (6) tick();

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      vld3 = 1'($urandom_range(0, 1));
      data3 = rnd64(); side3 = 1'($urandom);
      vld1 = ($urandom_range(0, 3) != 0);
      data1 = rnd64(); side1 = 1'($urandom);
      tick();
    end
    vld3 = 1'b0; vld1 = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
